branch_cmp_predictor: RTL and testbench
=======================================

Name: branch_cmp_predictor

Overview:
- Parametrised successor to the combinational branch comparator in the ID stage.
- Evaluates the 14 branch conditions on WIDTH-bit signed operands and registers the resolved outcome.
- Keeps a bimodal branch history table (BHT) of 2-bit saturating counters indexed by PC, used for early-fetch prediction.
- Flags mispredictions and keeps saturating branch and misprediction statistics for the perf counters.

Parameters:
- WIDTH, 32, operand width. Compares are two's-complement signed.
- BHT_ENTRIES, 16, number of BHT counters. Must be a power of 2, at least 2.
- INDEX_LSB, 2, lowest PC bit used for the index. The index is pc[INDEX_LSB +: log2(BHT_ENTRIES)].
- CNT_W, 16, width of each statistics counter.

Ports:
- clk, in, 1, clock. All state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- cmp_valid, in, 1, a branch is presented for resolution this cycle.
- stall, in, 1, freezes all sequential state.
- cmp_a, in, WIDTH, rs operand after forwarding.
- cmp_b, in, WIDTH, rt operand after forwarding.
- cmp_op, in, 4, condition code (see Behaviour).
- cmp_pc, in, 32, PC of the branch being resolved.
- bht_clear, in, 1, synchronous reset of all BHT counters.
- pred_pc, in, 32, fetch-stage PC for prediction lookup.
- pred_taken, out, 1, MSB of BHT[idx(pred_pc)]. Combinational.
- res_valid, out, 1, registered result valid.
- to_branch, out, 1, registered condition outcome.
- mispredict, out, 1, registered: outcome differs from the BHT prediction read at resolve time.
- branch_count, out, CNT_W, legal branches resolved. Saturating.
- mispredict_count, out, CNT_W, mispredictions. Saturating.

Behaviour:
- Condition codes:
  - 0 = a==b; 1 = a!=b.
  - 2..7 = a>=0, a>0, a<=0, a<0, a==0, a!=0.
  - 8..13 = the same six tests applied to b.
  - 14 and 15 are illegal: condition evaluates 0.
- Accept: a branch is accepted when cmp_valid=1 and stall=0.
- Latency 1. On an accepting edge:
  - res_valid<=1, to_branch<=cond.
  - Prediction p = MSB of BHT[idx(cmp_pc)], read before the update.
  - mispredict<=(cond!=p) for legal ops; 0 for illegal ops.
- Idle: on an edge with cmp_valid=0 and stall=0, res_valid, to_branch and mispredict all go to 0.
- stall=1: every register holds, including res_valid, the BHT and the statistics counters. cmp_valid is ignored.
- BHT update (legal op, accepted only):
  - Taken: counter+1, saturating at 2'b11.
  - Not taken: counter-1, saturating at 2'b00.
  - Illegal ops leave the BHT and statistics unchanged.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Reset and clear value is 01.
- bht_clear=1 and stall=0: all counters go to 01 at the edge. Clear wins over a simultaneous update.
  - The branch resolved in that cycle still produces res_valid, to_branch and mispredict (against the pre-clear p).
  - Its statistics still count.
- pred_taken has no bypass: a lookup in the same cycle as an update to the same index returns the old value.
- Aliasing: PCs that share an index share a counter. This is intended.
- Statistics:
  - branch_count increments on each accepted legal branch.
  - mispredict_count increments when mispredict is set.
  - Both hold at all-ones; there is no wrap.
- Reset (reset=0), asynchronous at any time, including mid-stall:
  - res_valid, to_branch and mispredict are 0.
  - All counters are 01.
  - Both statistics counters are 0.
  - pred_taken therefore reads 0.
  - The first edge after release behaves normally.

Decomposition:
- Shared package:
  - condition-code constants (CMP_BEQ..CMP_RT_BNEZ, 0..13);
  - 2-bit counter state constants (SNT, WNT, WT, ST) and the reset state WNT;
  - an index-width function (clog2 of BHT_ENTRIES).
- Sub-module branch_cond_eval: purely combinational, WIDTH-parametrised, (a, b, op) -> (cond, legal). It is instantiated once and is unit-testable on its own.
- The BHT array, result registers and statistics live in branch_cmp_predictor.

Test Plan (WIDTH=32, BHT_ENTRIES=16, INDEX_LSB=2):
1. Reset: hold reset=0, drive cmp_valid=1 with arbitrary stimulus and pred_pc=0x3000 -> res_valid=0, to_branch=0, mispredict=0, both counts 0, pred_taken=0. Release, idle one cycle -> all outputs unchanged.
2. Prediction and mispredict: resolve beq with a=5, b=5, pc=0x3000 -> next cycle res_valid=1, to_branch=1, mispredict=1; branch_count=1, mispredict_count=1. pred_pc=0x3000 -> pred_taken=1. pred_pc=0x3040 (aliases index 0) -> pred_taken=1.
3. Saturation at pc=0x3004:
   - Four taken bne (a=1, b=2) -> mispredict 1, 0, 0, 0; counter reaches 11.
   - One not-taken -> mispredict=1, counter 10, pred_taken stays 1.
4. Signed edges:
   - Op 5 with a=0x80000000 -> to_branch=1.
   - Op 3 with a=0x80000000 -> to_branch=0.
   - Op 8 with b=0 -> 1.
   - Op 12 with b=0xFFFFFFFF -> 0.
   - Op 4'hE -> to_branch=0, mispredict=0, BHT and counts unchanged.
5. Stall: accept a taken branch, then hold stall=1 for 3 cycles with cmp_valid=1 and a different op -> res_valid, to_branch and counts frozen. Drop stall -> new branch resolves 1 cycle later.
6. Clear race: bht_clear=1 together with a taken beq at 0x3000 whose counter is 11 -> next cycle to_branch=1, mispredict=0, branch_count incremented, BHT[0]=01 (pred_taken=0). Assert reset mid-run -> outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/branch_cmp_predictor_pkg.sv
// Shared definitions for the branch comparator/predictor:
// condition codes, BHT counter states and index sizing.
package branch_cmp_predictor_pkg;

  localparam logic [3:0] CMP_BEQ     = 4'd0;
  localparam logic [3:0] CMP_BNE     = 4'd1;
  localparam logic [3:0] CMP_RS_BGEZ = 4'd2;
  localparam logic [3:0] CMP_RS_BGTZ = 4'd3;
  localparam logic [3:0] CMP_RS_BLEZ = 4'd4;
  localparam logic [3:0] CMP_RS_BLTZ = 4'd5;
  localparam logic [3:0] CMP_RS_BEQZ = 4'd6;
  localparam logic [3:0] CMP_RS_BNEZ = 4'd7;
  localparam logic [3:0] CMP_RT_BGEZ = 4'd8;
  localparam logic [3:0] CMP_RT_BGTZ = 4'd9;
  localparam logic [3:0] CMP_RT_BLEZ = 4'd10;
  localparam logic [3:0] CMP_RT_BLTZ = 4'd11;
  localparam logic [3:0] CMP_RT_BEQZ = 4'd12;
  localparam logic [3:0] CMP_RT_BNEZ = 4'd13;

  localparam logic [1:0] SNT     = 2'b00;
  localparam logic [1:0] WNT     = 2'b01;
  localparam logic [1:0] WT      = 2'b10;
  localparam logic [1:0] ST      = 2'b11;
  localparam logic [1:0] CNT_RST = WNT;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the 14 signed branch
// conditions; codes 14/15 report illegal and evaluate 0.
module branch_cond_eval
  import branch_cmp_predictor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic             cond_o,
  output logic             legal_o
);

  logic a_z, a_n, b_z, b_n;

  assign a_z = (a_i == '0);
  assign b_z = (b_i == '0);
  assign a_n = a_i[WIDTH-1];
  assign b_n = b_i[WIDTH-1];

  always_comb begin
    cond_o  = 1'b0;
    legal_o = 1'b1;
    unique case (op_i)
      CMP_BEQ:     cond_o = (a_i == b_i);
      CMP_BNE:     cond_o = (a_i != b_i);
      CMP_RS_BGEZ: cond_o = !a_n;
      CMP_RS_BGTZ: cond_o = !a_n && !a_z;
      CMP_RS_BLEZ: cond_o = a_n || a_z;
      CMP_RS_BLTZ: cond_o = a_n;
      CMP_RS_BEQZ: cond_o = a_z;
      CMP_RS_BNEZ: cond_o = !a_z;
      CMP_RT_BGEZ: cond_o = !b_n;
      CMP_RT_BGTZ: cond_o = !b_n && !b_z;
      CMP_RT_BLEZ: cond_o = b_n || b_z;
      CMP_RT_BLTZ: cond_o = b_n;
      CMP_RT_BEQZ: cond_o = b_z;
      CMP_RT_BNEZ: cond_o = !b_z;
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_predictor.sv
// Registered branch resolution with a bimodal BHT,
// misprediction flag and saturating statistics.
module branch_cmp_predictor
  import branch_cmp_predictor_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int INDEX_LSB   = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic [3:0]       cmp_op,
  input  logic [31:0]      cmp_pc,
  input  logic             bht_clear,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic             res_valid,
  output logic             to_branch,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IW = idx_width(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             res_valid_q, res_valid_d;
  logic             to_branch_q, to_branch_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic          cond, legal, upd, p, miss;
  logic [IW-1:0] cmp_idx, pred_idx;
  logic [1:0]    cur;
  logic          unused_pc;

  branch_cond_eval #(.WIDTH(WIDTH)) u_eval (
    .a_i    (cmp_a),
    .b_i    (cmp_b),
    .op_i   (cmp_op),
    .cond_o (cond),
    .legal_o(legal)
  );

  assign cmp_idx   = cmp_pc[INDEX_LSB +: IW];
  assign pred_idx  = pred_pc[INDEX_LSB +: IW];
  assign unused_pc = ^{cmp_pc, pred_pc};

  assign pred_taken = bht_q[pred_idx][1];

  always_comb begin
    upd  = cmp_valid && legal;
    cur  = bht_q[cmp_idx];
    p    = cur[1];
    miss = upd && (cond != p);

    res_valid_d  = cmp_valid;
    to_branch_d  = cmp_valid && cond;
    mispredict_d = miss;

    br_cnt_d = br_cnt_q;
    if (upd && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + 1'b1;
    mp_cnt_d = mp_cnt_q;
    if (miss && (mp_cnt_q != '1))
      mp_cnt_d = mp_cnt_q + 1'b1;

    bht_d = bht_q;
    if (upd && cond && (cur != ST))
      bht_d[cmp_idx] = cur + 2'd1;
    else if (upd && !cond && (cur != SNT))
      bht_d[cmp_idx] = cur - 2'd1;
    // clear overrides the same-cycle training update
    if (bht_clear)
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_d[i] = CNT_RST;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_q  <= 1'b0;
      to_branch_q  <= 1'b0;
      mispredict_q <= 1'b0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= CNT_RST;
    end else if (!stall) begin
      res_valid_q  <= res_valid_d;
      to_branch_q  <= to_branch_d;
      mispredict_q <= mispredict_d;
      br_cnt_q     <= br_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= bht_d[i];
    end
  end

  assign res_valid        = res_valid_q;
  assign to_branch        = to_branch_q;
  assign mispredict       = mispredict_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_cmp_predictor.sv
// Scoreboard bench for branch_cmp_predictor with a
// behavioural BHT/statistics reference model.
module tb_branch_cmp_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmp_valid;
  logic        stall;
  logic [31:0] cmp_a, cmp_b;
  logic [3:0]  cmp_op;
  logic [31:0] cmp_pc;
  logic        bht_clear;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid, to_branch, mispredict;
  logic [15:0] branch_count, mispredict_count;

  typedef struct {
    logic        v;
    logic        t;
    logic        m;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t sb[$];
  exp_t e, held;
  int   mbht [16];
  int   mbc, mmc;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [34:0] obs, want;

  branch_cmp_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .cmp_valid       (cmp_valid),
    .stall           (stall),
    .cmp_a           (cmp_a),
    .cmp_b           (cmp_b),
    .cmp_op          (cmp_op),
    .cmp_pc          (cmp_pc),
    .bht_clear       (bht_clear),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .res_valid       (res_valid),
    .to_branch       (to_branch),
    .mispredict      (mispredict),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic mcond(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [31:0] x;
    int k;
    if (op == 4'd0) return a == b;
    if (op == 4'd1) return a != b;
    if (op > 4'd13) return 1'b0;
    x = (op < 4'd8) ? a : b;
    k = (op < 4'd8) ? int'(op) - 2 : int'(op) - 8;
    case (k)
      0: return x >= 0;
      1: return x > 0;
      2: return x <= 0;
      3: return x < 0;
      4: return x == 0;
      default: return x != 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mbht[i] = 1;
    mbc = 0;
    mmc = 0;
    sb.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] pc,
    input logic clr
  );
    exp_t x;
    logic c, lg, p;
    int i;
    cmp_valid = 1'b1;
    cmp_op    = op;
    cmp_a     = a;
    cmp_b     = b;
    cmp_pc    = pc;
    bht_clear = clr;
    c  = mcond(op, a, b);
    lg = (op < 4'd14);
    i  = int'(pc[5:2]);
    p  = (mbht[i] >= 2);
    x.v = 1'b1;
    x.t = c;
    x.m = lg && (c != p);
    if (lg) begin
      if (mbc < 65535) mbc++;
      if (x.m && mmc < 65535) mmc++;
      if (c && mbht[i] < 3) mbht[i]++;
      if (!c && mbht[i] > 0) mbht[i]--;
    end
    if (clr) for (int j = 0; j < 16; j++) mbht[j] = 1;
    x.bc = mbc[15:0];
    x.mc = mmc[15:0];
    sb.push_back(x);
  endtask

  task automatic idle();
    exp_t x;
    cmp_valid = 1'b0;
    bht_clear = 1'b0;
    x.v = 1'b0;
    x.t = 1'b0;
    x.m = 1'b0;
    x.bc = mbc[15:0];
    x.mc = mmc[15:0];
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    stall     = 1'b0;
    cmp_valid = 1'b1;
    cmp_op    = 4'd0;
    cmp_a     = 32'd5;
    cmp_b     = 32'd5;
    cmp_pc    = 32'h3000;
    bht_clear = 1'b0;
    pred_pc   = 32'h3000;
    model_reset();
    tick();
    tick();
    obs = {res_valid, to_branch, mispredict,
           branch_count, mispredict_count};
    n_checks++;
    if (obs !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outs got=%h exp=0", obs);
    end
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pred got=%b exp=0", pred_taken);
    end
    #2 reset = 1'b1;
    idle();
    tick();
    e = sb.pop_front();
    obs = {res_valid, to_branch, mispredict,
           branch_count, mispredict_count};
    n_checks++;
    if (obs !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_predict();
    issue(4'd0, 32'd5, 32'd5, 32'h3000, 1'b0);
    tick();
    e = sb.pop_front();
    obs = {res_valid, to_branch, mispredict,
           branch_count, mispredict_count};
    n_checks++;
    if (obs !== {3'b111, 16'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL beq_first got=%h exp=%h",
               obs, {3'b111, 16'd1, 16'd1});
    end
    idle();
    pred_pc = 32'h3000;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL pred_3000 got=%b exp=1", pred_taken);
    end
    pred_pc = 32'h3040;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL pred_alias got=%b exp=1", pred_taken);
    end
    tick();
    e = sb.pop_front();
  endtask

  task automatic test_saturate();
    logic [3:0] mp_exp;
    logic [3:0] mp_obs;
    mp_exp = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) issue(4'd1, 32'd1, 32'd2, 32'h3004, 1'b0);
      else       issue(4'd1, 32'd3, 32'd3, 32'h3004, 1'b0);
      tick();
      e = sb.pop_front();
      obs  = {res_valid, to_branch, mispredict,
              branch_count, mispredict_count};
      want = {e.v, e.t, e.m, e.bc, e.mc};
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL sat_step%0d got=%h exp=%h", k, obs, want);
      end
      if (k < 4) mp_obs[k] = mispredict;
      else if (mispredict !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_nt_mp got=%b exp=1", mispredict);
      end
      if (k == 4) n_checks++;
    end
    n_checks++;
    if (mp_obs !== mp_exp) begin
      n_fail++;
      $display("FAIL sat_mp_seq got=%b exp=%b", mp_obs, mp_exp);
    end
    pred_pc = 32'h3004;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pred got=%b exp=1", pred_taken);
    end
  endtask

  task automatic test_signed();
    logic [3:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic        tbx [5];
    logic [31:0] vals [6];
    ops = '{4'd5, 4'd3, 4'd8, 4'd12, 4'hE};
    as  = '{32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'd9};
    bs  = '{32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd9};
    tbx = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      issue(ops[k], as[k], bs[k], 32'h3008, 1'b0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (to_branch !== tbx[k]) begin
        n_fail++;
        $display("FAIL signed_op%0d got=%b exp=%b",
                 ops[k], to_branch, tbx[k]);
      end
      obs  = {res_valid, to_branch, mispredict,
              branch_count, mispredict_count};
      want = {e.v, e.t, e.m, e.bc, e.mc};
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL signed_sb%0d got=%h exp=%h", k, obs, want);
      end
    end
    pred_pc = 32'h3008;
    #1;
    n_checks++;
    if (pred_taken !== (mbht[2] >= 2)) begin
      n_fail++;
      $display("FAIL illegal_bht got=%b exp=%b",
               pred_taken, mbht[2] >= 2);
    end
    vals = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
             32'h7FFFFFFF, 32'd5};
    for (int k = 0; k < 40; k++) begin
      issue(4'($urandom_range(0, 15)),
            vals[$urandom_range(0, 5)],
            vals[$urandom_range(0, 5)],
            32'h3000 + 32'($urandom_range(0, 7)) * 4,
            1'b0);
      tick();
      e = sb.pop_front();
      obs  = {res_valid, to_branch, mispredict,
              branch_count, mispredict_count};
      want = {e.v, e.t, e.m, e.bc, e.mc};
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d got=%h exp=%h",
                 k, cmp_op, obs, want);
      end
    end
  endtask

  task automatic test_stall();
    issue(4'd0, 32'd7, 32'd7, 32'h300C, 1'b0);
    tick();
    held = sb.pop_front();
    stall     = 1'b1;
    cmp_valid = 1'b1;
    cmp_op    = 4'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      obs  = {res_valid, to_branch, mispredict,
              branch_count, mispredict_count};
      want = {held.v, held.t, held.m, held.bc, held.mc};
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL stall%0d got=%h exp=%h", k, obs, want);
      end
    end
    pred_pc = 32'h300C;
    #1;
    n_checks++;
    if (pred_taken !== (mbht[3] >= 2)) begin
      n_fail++;
      $display("FAIL stall_bht got=%b exp=%b",
               pred_taken, mbht[3] >= 2);
    end
    stall = 1'b0;
    issue(4'd1, 32'd1, 32'd2, 32'h300C, 1'b0);
    tick();
    e = sb.pop_front();
    obs  = {res_valid, to_branch, mispredict,
            branch_count, mispredict_count};
    want = {e.v, e.t, e.m, e.bc, e.mc};
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL unstall got=%h exp=%h", obs, want);
    end
  endtask

  task automatic test_clear();
    logic [15:0] bc0;
    for (int k = 0; k < 3; k++) begin
      issue(4'd0, 32'd4, 32'd4, 32'h3000, 1'b0);
      tick();
      e = sb.pop_front();
    end
    bc0 = branch_count;
    issue(4'd0, 32'd4, 32'd4, 32'h3000, 1'b1);
    tick();
    e = sb.pop_front();
    obs  = {res_valid, to_branch, mispredict,
            branch_count, mispredict_count};
    want = {e.v, e.t, e.m, e.bc, e.mc};
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL clear_race got=%h exp=%h", obs, want);
    end
    n_checks++;
    if ({to_branch, mispredict, branch_count}
        !== {2'b10, bc0 + 16'd1}) begin
      n_fail++;
      $display("FAIL clear_out got=%b%b/%0d exp=10/%0d",
               to_branch, mispredict, branch_count, bc0 + 1);
    end
    idle();
    pred_pc = 32'h3000;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pred got=%b exp=0", pred_taken);
    end
    tick();
    e = sb.pop_front();
    issue(4'd0, 32'd4, 32'd4, 32'h3000, 1'b0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_valid got=%b exp=1", res_valid);
    end
    #2 reset = 1'b0;
    #1;
    obs = {res_valid, to_branch, mispredict,
           branch_count, mispredict_count};
    n_checks++;
    if (obs !== 35'd0 || pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got=%h/%b exp=0/0",
               obs, pred_taken);
    end
    model_reset();
    #2 reset = 1'b1;
    issue(4'd0, 32'd1, 32'd1, 32'h3000, 1'b0);
    tick();
    e = sb.pop_front();
    obs  = {res_valid, to_branch, mispredict,
            branch_count, mispredict_count};
    want = {e.v, e.t, e.m, e.bc, e.mc};
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL post_rst got=%h exp=%h", obs, want);
    end
  endtask

  initial begin
    test_reset();
    test_predict();
    test_saturate();
    test_signed();
    test_stall();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
